// File: rtl/mtimer_io.sv
// Machine timer / software-interrupt device on the internal I/O bus.
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare value and the
// msip bit. Serves single-cycle word loads/stores and drives mtip/msip.
module mtimer_io #(
  parameter logic [31:0] MSIP_BASE     = 32'h0200_0000,
  parameter logic [31:0] MTIME_BASE    = 32'h0200_BFF8,
  parameter logic [31:0] MTIMECMP_BASE = 32'h0200_4000,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        io_req,
  input  logic        io_rw,
  input  logic [31:0] io_addr,
  input  logic [1:0]  io_size,
  input  logic [31:0] io_wr_data,
  output logic        io_ack,
  output logic        io_err,
  output logic [31:0] io_rd_data,
  output logic        mtip,
  output logic        msip
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] count_reg;
  logic [63:0] mtime_reg;
  logic [63:0] mtimecmp_reg;
  logic        msip_reg;
  logic        mtip_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [31:0] rd_data_reg;

  logic        tick;
  logic        shape_ok;
  logic        sel_msip;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        addr_hit;
  logic        wr_en;
  logic [31:0] rd_next;

  assign tick = (count_reg == TICK_LAST);

  // Only aligned full-word accesses to one of the five registers are legal.
  assign shape_ok     = (io_size == 2'd2) && (io_addr[1:0] == 2'b00);
  assign sel_msip     = shape_ok && (io_addr == MSIP_BASE);
  assign sel_mtime_lo = shape_ok && (io_addr == MTIME_BASE);
  assign sel_mtime_hi = shape_ok && (io_addr == MTIME_BASE + 32'd4);
  assign sel_cmp_lo   = shape_ok && (io_addr == MTIMECMP_BASE);
  assign sel_cmp_hi   = shape_ok && (io_addr == MTIMECMP_BASE + 32'd4);
  assign addr_hit     = sel_msip | sel_mtime_lo | sel_mtime_hi | sel_cmp_lo | sel_cmp_hi;
  assign wr_en        = io_req && io_rw && addr_hit;

  // Load data mux: reads see register values from before the access edge.
  always_comb begin
    rd_next = 32'h0;
    if (sel_msip)     rd_next = {31'b0, msip_reg};
    if (sel_mtime_lo) rd_next = mtime_reg[31:0];
    if (sel_mtime_hi) rd_next = mtime_reg[63:32];
    if (sel_cmp_lo)   rd_next = mtimecmp_reg[31:0];
    if (sel_cmp_hi)   rd_next = mtimecmp_reg[63:32];
  end

  // Prescaler: counts 0..TICK_DIV-1, unaffected by stores to mtime.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_reg <= 16'h0;
    end else if (tick) begin
      count_reg <= 16'h0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // mtime: a store to either half wins over the tick and suppresses the carry.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtime_reg <= 64'h0;
    end else if (wr_en && sel_mtime_lo) begin
      mtime_reg[31:0] <= io_wr_data;
    end else if (wr_en && sel_mtime_hi) begin
      mtime_reg[63:32] <= io_wr_data;
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  // mtimecmp: each half written independently.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtimecmp_reg <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr_en && sel_cmp_lo) begin
      mtimecmp_reg[31:0] <= io_wr_data;
    end else if (wr_en && sel_cmp_hi) begin
      mtimecmp_reg[63:32] <= io_wr_data;
    end
  end

  // msip: only bit 0 of the store data is kept.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      msip_reg <= 1'b0;
    end else if (wr_en && sel_msip) begin
      msip_reg <= io_wr_data[0];
    end
  end

  // mtip: registered unsigned compare of the current register values.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mtip_reg <= 1'b0;
    end else begin
      mtip_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

  // Response: one ack per request, one cycle later; faults return zero data.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      rd_data_reg <= 32'h0;
    end else begin
      ack_reg     <= io_req;
      err_reg     <= io_req && !addr_hit;
      rd_data_reg <= (io_req && !io_rw && addr_hit) ? rd_next : 32'h0;
    end
  end

  assign io_ack     = ack_reg;
  assign io_err     = err_reg;
  assign io_rd_data = rd_data_reg;
  assign mtip       = mtip_reg;
  assign msip       = msip_reg;

endmodule

// File: tb/tb_mtimer_io.sv
// Self-checking bench for mtimer_io: one instance with TICK_DIV=4 for the
// prescaler check, one with TICK_DIV=1 for cycle-exact timer and bus checks.
module tb_mtimer_io;

  localparam logic [31:0] MSIP_A  = 32'h0200_0000;
  localparam logic [31:0] MTIME_A = 32'h0200_BFF8;
  localparam logic [31:0] CMP_A   = 32'h0200_4000;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        req4, req1;
  logic        io_rw;
  logic [31:0] io_addr;
  logic [1:0]  io_size;
  logic [31:0] io_wr_data;
  logic        ack4, err4, mtip4, msip4;
  logic        ack1, err1, mtip1, msip1;
  logic [31:0] rd4, rd1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mtimer_io #(.MSIP_BASE(MSIP_A), .MTIME_BASE(MTIME_A), .MTIMECMP_BASE(CMP_A), .TICK_DIV(4)) u_dut4 (
    .clk_in(clk), .reset_in(reset_in), .io_req(req4), .io_rw(io_rw), .io_addr(io_addr),
    .io_size(io_size), .io_wr_data(io_wr_data), .io_ack(ack4), .io_err(err4),
    .io_rd_data(rd4), .mtip(mtip4), .msip(msip4));

  mtimer_io #(.MSIP_BASE(MSIP_A), .MTIME_BASE(MTIME_A), .MTIMECMP_BASE(CMP_A), .TICK_DIV(1)) u_dut1 (
    .clk_in(clk), .reset_in(reset_in), .io_req(req1), .io_rw(io_rw), .io_addr(io_addr),
    .io_size(io_size), .io_wr_data(io_wr_data), .io_ack(ack1), .io_err(err1),
    .io_rd_data(rd1), .mtip(mtip1), .msip(msip1));

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic        exp_msip;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called #1 after an edge; the request is sampled at the next edge and the
  // response is read #1 after that edge.
  task automatic access(input int sel, input logic rw, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic ack, output logic err, output logic [31:0] rd);
    io_rw = rw; io_addr = addr; io_size = size; io_wr_data = wdata;
    if (sel == 4) req4 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    if (sel == 4) begin ack = ack4; err = err4; rd = rd4; end
    else          begin ack = ack1; err = err1; rd = rd1; end
    req4 = 1'b0; req1 = 1'b0;
    $display("xact dut%0d rw=%0d addr=%08h size=%0d wdata=%08h -> ack=%0d err=%0d rd=%08h",
             sel, rw, addr, size, wdata, ack, err, rd);
  endtask

  task automatic ld(input int sel, input logic [31:0] addr, input logic [31:0] exp, input string nm);
    logic a, e;
    logic [31:0] r;
    access(sel, 1'b0, addr, 2'd2, 32'h0, a, e, r);
    chk({nm, "_ack"}, 64'(a), 64'd1);
    chk({nm, "_err"}, 64'(e), 64'd0);
    chk({nm, "_rd"},  64'(r), 64'(exp));
  endtask

  task automatic st(input int sel, input logic [31:0] addr, input logic [31:0] data, input string nm);
    logic a, e;
    logic [31:0] r;
    access(sel, 1'b1, addr, 2'd2, data, a, e, r);
    chk({nm, "_ack"}, 64'(a), 64'd1);
    chk({nm, "_err"}, 64'(e), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic a, e;
    logic [31:0] r, v1, v2;

    vecs[0]  = '{"msip_set",      1'b1, MSIP_A,          2'd2, 32'h5,         1'b0, 32'h0,         1'b1};
    vecs[1]  = '{"msip_rd1",      1'b0, MSIP_A,          2'd2, 32'h0,         1'b0, 32'h1,         1'b1};
    vecs[2]  = '{"msip_clr",      1'b1, MSIP_A,          2'd2, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[3]  = '{"msip_rd0",      1'b0, MSIP_A,          2'd2, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[4]  = '{"msip_bit0",     1'b1, MSIP_A,          2'd2, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{"cmp_lo_rd",     1'b0, CMP_A,           2'd2, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{"cmp_hi_rd",     1'b0, CMP_A + 32'd4,   2'd2, 32'h0,         1'b0, 32'h0,         1'b0};
    vecs[7]  = '{"f_size1",       1'b0, MTIME_A,         2'd1, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[8]  = '{"f_misalign",    1'b0, MTIME_A + 32'd2, 2'd2, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[9]  = '{"f_msip8_wr",    1'b1, MSIP_A + 32'd8,  2'd2, 32'h1,         1'b1, 32'h0,         1'b0};
    vecs[10] = '{"f_cmp_byte_wr", 1'b1, CMP_A,           2'd0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[11] = '{"cmp_unchanged", 1'b0, CMP_A,           2'd2, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{"f_size3",       1'b0, MSIP_A,          2'd3, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[13] = '{"f_unmapped",    1'b0, 32'h0200_0010,   2'd2, 32'h0,         1'b1, 32'h0,         1'b0};

    reset_in = 1'b1; req4 = 1'b0; req1 = 1'b0;
    io_rw = 1'b0; io_addr = 32'h0; io_size = 2'd2; io_wr_data = 32'h0;

    // Reset held for two edges: every output low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs4", {59'b0, ack4, err4, mtip4, msip4, |rd4}, 64'd0);
    chk("rst_outs1", {59'b0, ack1, err1, mtip1, msip1, |rd1}, 64'd0);
    reset_in = 1'b0;

    // First edges after reset: mtimecmp high word reads its reset value.
    ld(4, CMP_A + 32'd4, 32'hFFFF_FFFF, "rst_cmp_hi4");
    ld(1, CMP_A + 32'd4, 32'hFFFF_FFFF, "rst_cmp_hi1");

    // Prescaler of 4: about 40 cycles after reset mtime is 10.
    idle(38);
    access(4, 1'b0, MTIME_A, 2'd2, 32'h0, a, e, v1);
    chk("div4_range", 64'((v1 >= 32'd9) && (v1 <= 32'd11)), 64'd1);
    idle(3);
    access(4, 1'b0, MTIME_A, 2'd2, 32'h0, a, e, v2);
    chk("div4_step", 64'(v2 - v1), 64'd1);
    ld(4, MTIME_A + 32'd4, 32'h0, "div4_hi");

    // mtip timing with TICK_DIV=1.
    st(1, CMP_A + 32'd4, 32'h0, "cmp_hi_w");
    st(1, MTIME_A, 32'h0, "mtime_lo_zero");   // mtime = j after edge A+j
    st(1, CMP_A, 32'd20, "cmp_lo_20");
    for (int j = 2; j <= 25; j++) begin
      @(posedge clk); #1;
      chk($sformatf("mtip_j%0d", j), 64'(mtip1), 64'(j >= 21));
    end
    st(1, CMP_A, 32'hFFFF_FFFF, "cmp_lo_max");
    chk("mtip_still_set", 64'(mtip1), 64'd1);
    idle(1);
    chk("mtip_cleared", 64'(mtip1), 64'd0);

    // 64-bit wrap and store-beats-tick.
    st(1, MTIME_A + 32'd4, 32'hFFFF_FFFF, "wrap_hi_w");
    st(1, MTIME_A, 32'hFFFF_FFFE, "wrap_lo_w");
    ld(1, MTIME_A + 32'd4, 32'hFFFF_FFFF, "wrap_hi_pre");
    ld(1, MTIME_A, 32'hFFFF_FFFF, "wrap_lo_pre");
    ld(1, MTIME_A + 32'd4, 32'h0, "wrap_hi_post");
    ld(1, MTIME_A, 32'h1, "wrap_lo_post");
    st(1, MTIME_A, 32'hFFFF_FFFF, "tick_lo_w");
    ld(1, MTIME_A, 32'hFFFF_FFFF, "tick_lo_exact");
    ld(1, MTIME_A + 32'd4, 32'h1, "tick_carry_later");
    st(1, MTIME_A + 32'd4, 32'h5, "tick_hi_w");
    ld(1, MTIME_A + 32'd4, 32'h5, "tick_hi_exact");

    // Table: msip, register reads and faults, all issued back to back.
    for (int i = 0; i < 14; i++) begin
      access(1, vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].wdata, a, e, r);
      chk({vecs[i].name, "_ack"}, 64'(a), 64'd1);
      chk({vecs[i].name, "_err"}, 64'(e), 64'(vecs[i].exp_err));
      if (!vecs[i].rw || vecs[i].exp_err)
        chk({vecs[i].name, "_rd"}, 64'(r), 64'(vecs[i].exp_rd));
      chk({vecs[i].name, "_msip"}, 64'(msip1), 64'(vecs[i].exp_msip));
    end
    idle(1);
    chk("ack_idle", 64'(ack1), 64'd0);

    // Request during reset is dropped: no ack, no write.
    reset_in = 1'b1;
    access(1, 1'b1, MSIP_A, 2'd2, 32'h1, a, e, r);
    chk("rst_req_ack", 64'(a), 64'd0);
    chk("rst_req_msip", 64'(msip1), 64'd0);
    reset_in = 1'b0;
    ld(1, CMP_A, 32'hFFFF_FFFF, "rst_again_cmp");
    ld(1, MSIP_A, 32'h0, "rst_again_msip");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
